// File: rtl/prog_seq_ctrl.sv
// prog_seq_ctrl: loads a program into memory, starts and paces the core
// (free-run or single-step), then streams a full memory readout for display.
module prog_seq_ctrl #(
  parameter int          DEPTH   = 128,
  parameter int          AW      = 7,
  parameter int          DW      = 24,
  parameter logic [7:0]  HALT_OP = 8'h00
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          load_req,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic          cpu_halted,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_pc_rst,
  output logic          cpu_en,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  input  logic          dump_ready,
  output logic [2:0]    state,
  output logic [AW:0]   prog_len,
  output logic          overflow
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_READY = 3'd1,
    S_RUN   = 3'd2,
    S_DUMP  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   load_ptr_q, load_ptr_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] dump_addr_q, dump_addr_d;
  logic          step_pend_q, step_pend_d;

  logic accept, is_halt, go_run, xfer;

  // Handshake and strobe decode; all gated off while reset is held.
  always_comb begin
    // A concurrent load_req restarts the load, so the word is not taken.
    in_ready   = !reset && (state_q == S_LOAD) && !load_req;
    accept     = in_ready && in_valid;
    mem_we     = accept;
    mem_addr   = load_ptr_q[AW-1:0];
    mem_wdata  = in_data;
    is_halt    = (in_data[DW-1 -: 8] == HALT_OP);
    go_run     = !reset && !load_req && start &&
                 ((state_q == S_READY) || (state_q == S_DONE));
    cpu_pc_rst = go_run;
    // Halt always wins; in step mode only the cycle after an accepted step runs.
    cpu_en     = !reset && (state_q == S_RUN) && !cpu_halted &&
                 (!step_mode || step_pend_q);
    dump_valid = !reset && (state_q == S_DUMP);
    xfer       = dump_valid && dump_ready;
    dump_addr  = dump_addr_q;
    state      = state_q;
    prog_len   = prog_len_q;
    overflow   = overflow_q;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    load_ptr_d  = load_ptr_q;
    prog_len_d  = prog_len_q;
    overflow_d  = overflow_q;
    dump_addr_d = dump_addr_q;
    // Steps arriving while the previous one is still executing are dropped.
    step_pend_d = (state_q == S_RUN) && step_mode && step &&
                  !step_pend_q && !cpu_halted;
    case (state_q)
      S_LOAD: begin
        if (load_req) begin
          load_ptr_d = '0;
          prog_len_d = '0;
          overflow_d = 1'b0;
        end else if (accept) begin
          if (is_halt) begin
            load_ptr_d = load_ptr_q + 1'b1;
            prog_len_d = load_ptr_q + 1'b1;
            state_d    = S_READY;
          end else if (load_ptr_q == (AW+1)'(DEPTH-1)) begin
            // Last slot filled without HALT: pointer stays put, no wrap.
            overflow_d = 1'b1;
            state_d    = S_ERROR;
          end else begin
            load_ptr_d = load_ptr_q + 1'b1;
          end
        end
      end
      S_READY, S_DONE, S_ERROR: begin
        if (load_req) begin
          load_ptr_d = '0;
          prog_len_d = '0;
          overflow_d = 1'b0;
          state_d    = S_LOAD;
        end else if (go_run) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cpu_halted) begin
          dump_addr_d = '0;
          state_d     = S_DUMP;
        end
      end
      S_DUMP: begin
        if (xfer) begin
          if (dump_addr_q == AW'(DEPTH-1)) begin
            dump_addr_d = '0;
            state_d     = S_DONE;
          end else begin
            dump_addr_d = dump_addr_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      load_ptr_q  <= '0;
      prog_len_q  <= '0;
      overflow_q  <= 1'b0;
      dump_addr_q <= '0;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_ptr_q  <= load_ptr_d;
      prog_len_q  <= prog_len_d;
      overflow_q  <= overflow_d;
      dump_addr_q <= dump_addr_d;
      step_pend_q <= step_pend_d;
    end
  end

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Directed bench for prog_seq_ctrl: load, free-run, step, dump, overflow, reset.
module tb_prog_seq_ctrl;
  localparam int AW = 7;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, load_req, start, step_mode, step;
  logic          cpu_halted, mem_we, cpu_pc_rst, cpu_en, dump_valid, dump_ready;
  logic          overflow;
  logic [DW-1:0] in_data, mem_wdata;
  logic [AW-1:0] mem_addr, dump_addr;
  logic [2:0]    state;
  logic [AW:0]   prog_len;

  int checks = 0;
  int failures = 0;
  int pulses;

  prog_seq_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .load_req(load_req), .start(start),
    .step_mode(step_mode), .step(step), .cpu_halted(cpu_halted),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_pc_rst(cpu_pc_rst), .cpu_en(cpu_en), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_ready(dump_ready), .state(state),
    .prog_len(prog_len), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step one clock; inputs change 1ns after the edge, checks 2ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; in_valid = 1; in_data = 24'h010000; load_req = 0; start = 0;
    step_mode = 0; step = 0; cpu_halted = 0; dump_ready = 0;
    cyc(); cyc();
    #2;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_pc_rst", cpu_pc_rst, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_state", state, 0);
    in_valid = 0; reset = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_prog_len", prog_len, 0);
    chk("post_rst_overflow", overflow, 0);

    // Three-word program ending in HALT.
    cyc();
    in_valid = 1; in_data = 24'h020105; #2;
    chk("ld0_we", mem_we, 1); chk("ld0_addr", mem_addr, 0); chk("ld0_data", mem_wdata, 24'h020105);
    cyc();
    in_data = 24'h080100; #2;
    chk("ld1_we", mem_we, 1); chk("ld1_addr", mem_addr, 1); chk("ld1_data", mem_wdata, 24'h080100);
    cyc();
    in_data = 24'h000000; #2;
    chk("ld2_we", mem_we, 1); chk("ld2_addr", mem_addr, 2);
    cyc();
    #2;
    chk("ready_state", state, 1);
    chk("ready_prog_len", prog_len, 3);
    chk("ready_in_ready", in_ready, 0);
    chk("ready_mem_we", mem_we, 0);
    in_valid = 0;

    // Free-run: start, five executing cycles, then halt.
    cyc();
    start = 1; #2;
    chk("fr_pc_rst", cpu_pc_rst, 1);
    chk("fr_en_at_start", cpu_en, 0);
    cyc();
    start = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("fr_state", state, 2);
      chk("fr_pc_rst_low", cpu_pc_rst, 0);
      if (cpu_en) pulses++;
      cyc();
    end
    chk("fr_en_cycles", pulses, 5);
    cpu_halted = 1; #2;
    chk("fr_halt_en", cpu_en, 0);
    cyc();
    cpu_halted = 0; #2;
    chk("fr_dump_state", state, 3);
    chk("fr_dump_addr0", dump_addr, 0);
    chk("fr_dump_valid", dump_valid, 1);

    // Dump with dump_ready toggling; each address held across its stall.
    for (int n = 0; n < 128; n++) begin
      dump_ready = 0; #2;
      chk("dmp_stall_addr", dump_addr, n);
      chk("dmp_stall_valid", dump_valid, 1);
      cyc();
      dump_ready = 1; #2;
      chk("dmp_xfer_addr", dump_addr, n);
      cyc();
    end
    dump_ready = 0; #2;
    chk("dmp_done_state", state, 4);
    chk("dmp_done_valid", dump_valid, 0);

    // Rerun from DONE in step mode.
    cyc();
    step_mode = 1; start = 1; #2;
    chk("rerun_pc_rst", cpu_pc_rst, 1);
    cyc();
    start = 0; #2;
    chk("rerun_state", state, 2);
    chk("step_idle_en", cpu_en, 0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      step = 1; #2;
      chk("step_same_cyc", cpu_en, 0);
      cyc();
      step = 0; #2;
      chk("step_en_hi", cpu_en, 1);
      if (cpu_en) pulses++;
      cyc(); #2;
      chk("step_en_lo", cpu_en, 0);
      if (cpu_en) pulses++;
      cyc(); #2;
      if (cpu_en) pulses++;
    end
    chk("step_pulses", pulses, 3);

    // Second step while cpu_en is high is dropped.
    cyc();
    step = 1;
    cyc();
    #2;
    chk("drop_en_hi", cpu_en, 1);
    cyc();
    step = 0; #2;
    chk("drop_en_lo", cpu_en, 0);

    // Step and halt together: no execution, go to DUMP.
    cyc();
    step = 1; cpu_halted = 1; #2;
    chk("sh_en", cpu_en, 0);
    cyc();
    step = 0; cpu_halted = 0; #2;
    chk("sh_en_next", cpu_en, 0);
    chk("sh_state", state, 3);

    // load_req and start ignored in DUMP.
    load_req = 1; start = 1; #2;
    chk("dmp_ldreq_in_ready", in_ready, 0);
    chk("dmp_start_pc_rst", cpu_pc_rst, 0);
    cyc();
    load_req = 0; start = 0; #2;
    chk("dmp_ldreq_ignored", state, 3);
    dump_ready = 1;
    for (int n = 0; n < 128; n++) cyc();
    dump_ready = 0; #2;
    chk("dmp2_done", state, 4);

    // load_req beats start in DONE.
    load_req = 1; start = 1; #2;
    chk("prio_pc_rst", cpu_pc_rst, 0);
    cyc();
    load_req = 0; start = 0; step_mode = 0; #2;
    chk("prio_state", state, 0);
    chk("prio_prog_len", prog_len, 0);

    // Overflow: 128 non-HALT words.
    for (int i = 0; i < 128; i++) begin
      in_valid = 1; in_data = 24'h010000 + 24'(i); #2;
      if (i == 0 || i == 127) begin
        chk("ovf_we", mem_we, 1);
        chk("ovf_addr", mem_addr, i);
      end
      cyc();
    end
    #2;
    chk("ovf_state", state, 5);
    chk("ovf_flag", overflow, 1);
    chk("ovf_129_ready", in_ready, 0);
    chk("ovf_129_we", mem_we, 0);
    in_valid = 0;
    load_req = 1;
    cyc();
    load_req = 0; #2;
    chk("ovf_clr_state", state, 0);
    chk("ovf_clr_flag", overflow, 0);

    // Reset after two of four words; reload starts at address 0.
    in_valid = 1; in_data = 24'h010001;
    cyc();
    in_data = 24'h010002; #2;
    chk("mid_addr1", mem_addr, 1);
    cyc();
    in_valid = 0; reset = 1;
    cyc();
    reset = 0; #2;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_prog_len", prog_len, 0);
    in_valid = 1; in_data = 24'h000000; #1;
    chk("mid_reload_addr", mem_addr, 0);
    chk("mid_reload_we", mem_we, 1);
    cyc();
    in_valid = 0; #2;
    chk("mid_reload_len", prog_len, 1);
    chk("mid_reload_state", state, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_seq_ctrl.md
PROG_SEQ_CTRL -- requirements
Module: prog_seq_ctrl

Interface
REQ-001 Parameter DEPTH, default 128, SHALL set the program/data memory depth in words.
REQ-002 Parameter AW, default 7, SHALL set the memory address width (2^AW = DEPTH).
REQ-003 Parameter DW, default 24, SHALL set the instruction word width.
REQ-004 Parameter HALT_OP, default 8'h00, SHALL set the opcode value in bits [23:16] that marks end of program.
REQ-005 clk input 1: the single clock; all state SHALL update on its rising edge.
REQ-006 reset input 1: synchronous, active-high reset, sampled on the clk rising edge.
REQ-007 in_valid input 1: loader word valid.
REQ-008 in_data input DW: loader instruction word.
REQ-009 in_ready output 1: controller accepts in_data this cycle.
REQ-010 load_req input 1: single-cycle pulse; restarts loading from address 0.
REQ-011 start input 1: single-cycle pulse; begins execution.
REQ-012 step_mode input 1: 1 = single-step, 0 = free-run.
REQ-013 step input 1: single-cycle pulse; advances one instruction in step mode.
REQ-014 cpu_halted input 1: core has executed HALT.
REQ-015 mem_we output 1: memory write strobe.
REQ-016 mem_addr output AW: memory write address.
REQ-017 mem_wdata output DW: memory write data.
REQ-018 cpu_pc_rst output 1: clears the core program counter.
REQ-019 cpu_en output 1: core executes one instruction in each cycle this is high.
REQ-020 dump_valid output 1, dump_addr output AW, dump_ready input 1: register/memory readout handshake to the display path.
REQ-021 state output 3: current FSM state encoding.
REQ-022 prog_len output AW+1: number of words loaded, including the HALT word.
REQ-023 overflow output 1: program did not fit in memory.

Function
REQ-024 States SHALL be LOAD=0, READY=1, RUN=2, DUMP=3, DONE=4, ERROR=5.
REQ-025 LOAD: in_ready=1; on in_valid&&in_ready, mem_we=1, mem_addr=load_ptr, mem_wdata=in_data in the same cycle (combinational), and load_ptr increments next cycle.
REQ-026 LOAD: accepted word with in_data[23:16]==HALT_OP SHALL be written, set prog_len=load_ptr+1, and go to READY.
REQ-027 LOAD: accepted non-HALT word at load_ptr==DEPTH-1 SHALL be written, set overflow=1, and go to ERROR; load_ptr SHALL not wrap.
REQ-028 in_ready SHALL be 0 in every state except LOAD; mem_we SHALL be 0 outside LOAD.
REQ-029 READY: start SHALL assert cpu_pc_rst for exactly one cycle and enter RUN on the next edge.
REQ-030 RUN, step_mode=0: cpu_en=1 every cycle cpu_halted=0.
REQ-031 RUN, step_mode=1: cpu_en=1 for exactly one cycle per step pulse, in the cycle after step is sampled; step pulses while cpu_en already high SHALL be dropped.
REQ-032 RUN: cpu_halted=1 SHALL force cpu_en=0 that cycle (halt wins over step/free-run) and go to DUMP with dump_addr=0.
REQ-033 DUMP: dump_valid=1; on dump_valid&&dump_ready, dump_addr increments; transfer at dump_addr==DEPTH-1 SHALL go to DONE with dump_valid=0 next cycle.
REQ-034 DUMP: dump_addr and dump_valid SHALL hold while dump_ready=0.
REQ-035 DONE: start SHALL rerun (cpu_pc_rst one cycle, then RUN) without reloading; load_req SHALL go to LOAD.
REQ-036 load_req in READY, DONE or ERROR SHALL go to LOAD, clear load_ptr, prog_len and overflow; load_req in RUN or DUMP SHALL be ignored.
REQ-037 start outside READY/DONE SHALL be ignored; start and load_req in the same cycle: load_req wins.
REQ-038 load_ptr is AW+1 bits; prog_len arithmetic SHALL be unsigned AW+1 bits.

Reset
REQ-039 reset SHALL, in any state including mid-load or mid-dump, set state=LOAD, load_ptr=0, prog_len=0, overflow=0, dump_addr=0.
REQ-040 During and after reset, outputs SHALL be in_ready=1 (after reset released), mem_we=0, cpu_en=0, cpu_pc_rst=0, dump_valid=0.

Verification
REQ-041 Load 3 words 0x020105, 0x080100, 0x000000 with in_valid=1 -> writes at addr 0,1,2; prog_len=3; state=READY; in_ready=0.
REQ-042 start in READY, step_mode=0, cpu_halted raised 5 cycles later -> cpu_pc_rst 1 cycle, cpu_en high 5 cycles then 0, state=DUMP.
REQ-043 step_mode=1, three step pulses 4 cycles apart -> exactly three single-cycle cpu_en pulses; step and cpu_halted same cycle -> no cpu_en, state=DUMP.
REQ-044 DUMP with dump_ready toggled every other cycle -> dump_addr 0..127 each presented once, held while stalled, state=DONE after 128 transfers.
REQ-045 128 non-HALT words -> all written, overflow=1, state=ERROR, 129th word not accepted; load_req -> state=LOAD, overflow=0.
REQ-046 reset asserted after 2 of 4 loaded words -> state=LOAD, load_ptr=0, prog_len=0; reload writes from address 0.
